// File: rtl/cmac_block_packer.sv
// Packs a 32-bit valid/ready word stream into 128-bit CMAC blocks and sequences key/block loads.
// Optional CMAC_PACKER_BYTE_SWAP_EN: byte-reverse each input word before packing.
module cmac_block_packer (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic         key_start,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic [2:0]   s_bytes,
  output logic         s_ready,
  output logic         cm_ld_Key,
  output logic         cm_ld_Block,
  output logic         cm_Last_Block,
  output logic [7:0]   cm_Last_Block_Len,
  output logic [127:0] cm_TextIn,
  input  logic         cm_Done,
  output logic         key_loaded,
  output logic         mac_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEY_WAIT, BLK_WAIT} state_t;

  state_t         state_q, state_d;
  logic [127:0]   asm_data_q, asm_data_d;
  logic [1:0]     asm_idx_q, asm_idx_d;
  logic [4:0]     asm_bytes_q, asm_bytes_d;
  logic           asm_closed_q, asm_closed_d;
  logic           asm_last_q, asm_last_d;
  logic           s_ready_q, s_ready_d;
  logic           hold_valid_q, hold_valid_d;
  logic [127:0]   text_q, text_d;
  logic           last_blk_q, last_blk_d;
  logic [7:0]     len_q, len_d;
  logic           ld_key_q, ld_key_d;
  logic           ld_block_q, ld_block_d;
  logic           key_loaded_q, key_loaded_d;
  logic           mac_valid_q, mac_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [31:0]    word_sw, word_m;
  logic [2:0]     nb;
  logic           accept, move, done_fall;

  assign nb = !s_last ? 3'd4 : ((s_bytes > 3'd4) ? 3'd4 : s_bytes);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
`ifdef CMAC_PACKER_BYTE_SWAP_EN
      assign word_sw[31-8*gi -: 8] = s_data[8*gi +: 8];
`else
      assign word_sw[31-8*gi -: 8] = s_data[31-8*gi -: 8];
`endif
      // Bytes past the valid count are zeroed; the core applies padding itself.
      assign word_m[31-8*gi -: 8] = (nb > 3'(gi)) ? word_sw[31-8*gi -: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    accept    = s_valid & s_ready_q;
    move      = asm_closed_q & ~hold_valid_q;
    done_fall = done_q & ~cm_Done;

    state_d      = state_q;
    asm_data_d   = asm_data_q;
    asm_idx_d    = asm_idx_q;
    asm_bytes_d  = asm_bytes_q;
    asm_closed_d = asm_closed_q;
    asm_last_d   = asm_last_q;
    hold_valid_d = hold_valid_q;
    text_d       = text_q;
    last_blk_d   = last_blk_q;
    len_d        = len_q;
    key_loaded_d = key_loaded_q;
    ld_key_d     = 1'b0;
    ld_block_d   = 1'b0;
    mac_valid_d  = 1'b0;
    done_d       = cm_Done;

    if (move) begin
      hold_valid_d = 1'b1;
      text_d       = asm_data_q;
      last_blk_d   = asm_last_q;
      len_d        = {asm_bytes_q, 3'b000};
      asm_data_d   = '0;
      asm_idx_d    = 2'd0;
      asm_bytes_d  = 5'd0;
      asm_closed_d = 1'b0;
      asm_last_d   = 1'b0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (asm_idx_q == 2'(i)) asm_data_d[127-32*i -: 32] = word_m;
      end
      asm_bytes_d = asm_bytes_q + {2'b00, nb};
      asm_last_d  = s_last;
      if (s_last || asm_idx_q == 2'd3) asm_closed_d = 1'b1;
      else                             asm_idx_d    = asm_idx_q + 2'd1;
    end

    s_ready_d = ~asm_closed_d;

    case (state_q)
      IDLE: begin
        // A block landing in hold this edge may be loaded on the same edge.
        if (key_loaded_q && (hold_valid_q || move)) begin
          state_d    = BLK_WAIT;
          ld_block_d = 1'b1;
        end else if (key_start && !hold_valid_q && !move) begin
          state_d  = KEY_WAIT;
          ld_key_d = 1'b1;
        end
      end
      KEY_WAIT: begin
        if (done_fall) begin
          state_d      = IDLE;
          key_loaded_d = 1'b1;
        end
      end
      BLK_WAIT: begin
        if (done_fall) begin
          state_d      = IDLE;
          hold_valid_d = 1'b0;
          mac_valid_d  = last_blk_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      asm_data_q   <= '0;
      asm_idx_q    <= 2'd0;
      asm_bytes_q  <= 5'd0;
      asm_closed_q <= 1'b0;
      asm_last_q   <= 1'b0;
      s_ready_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      text_q       <= '0;
      last_blk_q   <= 1'b0;
      len_q        <= 8'd0;
      ld_key_q     <= 1'b0;
      ld_block_q   <= 1'b0;
      key_loaded_q <= 1'b0;
      mac_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_data_q   <= asm_data_d;
      asm_idx_q    <= asm_idx_d;
      asm_bytes_q  <= asm_bytes_d;
      asm_closed_q <= asm_closed_d;
      asm_last_q   <= asm_last_d;
      s_ready_q    <= s_ready_d;
      hold_valid_q <= hold_valid_d;
      text_q       <= text_d;
      last_blk_q   <= last_blk_d;
      len_q        <= len_d;
      ld_key_q     <= ld_key_d;
      ld_block_q   <= ld_block_d;
      key_loaded_q <= key_loaded_d;
      mac_valid_q  <= mac_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign s_ready           = s_ready_q;
  assign cm_ld_Key         = ld_key_q;
  assign cm_ld_Block       = ld_block_q;
  assign cm_Last_Block     = last_blk_q;
  assign cm_Last_Block_Len = len_q;
  assign cm_TextIn         = text_q;
  assign key_loaded        = key_loaded_q;
  assign mac_valid         = mac_valid_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_cmac_block_packer.sv
// Directed bench for cmac_block_packer: key load, block packing, double buffering, reset.
module tb_cmac_block_packer;

  logic         CLK = 1'b0;
  logic         Rst_n;
  logic         key_start;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic [2:0]   s_bytes;
  logic         s_ready;
  logic         cm_ld_Key;
  logic         cm_ld_Block;
  logic         cm_Last_Block;
  logic [7:0]   cm_Last_Block_Len;
  logic [127:0] cm_TextIn;
  logic         cm_Done;
  logic         key_loaded;
  logic         mac_valid;
  logic         busy;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] BLK1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] BLK2 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] BLK3 = 128'h30c81c46a35ce411_0000000000000000;

  cmac_block_packer dut (
    .CLK(CLK), .Rst_n(Rst_n), .key_start(key_start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_bytes(s_bytes),
    .s_ready(s_ready), .cm_ld_Key(cm_ld_Key), .cm_ld_Block(cm_ld_Block),
    .cm_Last_Block(cm_Last_Block), .cm_Last_Block_Len(cm_Last_Block_Len),
    .cm_TextIn(cm_TextIn), .cm_Done(cm_Done), .key_loaded(key_loaded),
    .mac_valid(mac_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word and return just after the edge that accepts it.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nbytes);
    int n;
    s_valid = 1'b1; s_data = d; s_last = last; s_bytes = nbytes;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", {127'd0, s_ready}, 128'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0; s_bytes = 3'd0;
    $display("word %h last=%0d bytes=%0d accepted at %0t", d, last, nbytes, $time);
  endtask

  // Done high for hi cycles, then the falling edge; checks state just after the fall.
  task automatic pulse_done(input int hi, input logic exp_mac);
    cm_Done = 1'b1;
    tick();
    check("ld_one_cycle", {126'd0, cm_ld_Block, cm_ld_Key}, 128'd0);
    repeat (hi - 1) tick();
    cm_Done = 1'b0;
    tick();
    check("busy_after_fall", {127'd0, busy}, 128'd0);
    check("mac_valid_fall", {127'd0, mac_valid}, {127'd0, exp_mac});
    tick();
    check("mac_valid_pulse", {127'd0, mac_valid}, 128'd0);
    $display("done fall handled, mac_valid expected %0d", exp_mac);
  endtask

  task automatic check_block(input string tag, input logic [127:0] data, input logic [7:0] len,
                             input logic last);
    check({tag, "_ld"}, {127'd0, cm_ld_Block}, 128'd1);
    check({tag, "_data"}, cm_TextIn, data);
    check({tag, "_len"}, {120'd0, cm_Last_Block_Len}, {120'd0, len});
    check({tag, "_last"}, {127'd0, cm_Last_Block}, {127'd0, last});
    $display("block %s data=%h len=%0d last=%0d", tag, cm_TextIn, cm_Last_Block_Len, cm_Last_Block);
  endtask

  initial begin
    Rst_n = 1'b0; key_start = 1'b0; s_data = '0; s_valid = 1'b0;
    s_last = 1'b0; s_bytes = 3'd0; cm_Done = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {s_ready, cm_ld_Key, cm_ld_Block, cm_Last_Block, key_loaded, mac_valid, busy}, 128'd0);
    check("rst_text", cm_TextIn, 128'd0);
    Rst_n = 1'b1;
    tick();
    check("ready_after_rst", {127'd0, s_ready}, 128'd1);

    // Key load
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check("ld_key", {127'd0, cm_ld_Key}, 128'd1);
    check("busy_key", {127'd0, busy}, 128'd1);
    pulse_done(2, 1'b0);
    check("key_loaded", {127'd0, key_loaded}, 128'd1);

    // Empty message
    send_word(32'hffffffff, 1'b1, 3'd0);
    check("empty_ready_low", {127'd0, s_ready}, 128'd0);
    tick();
    check_block("empty", 128'd0, 8'd0, 1'b1);
    pulse_done(1, 1'b1);

    // One full block
    send_word(32'h6bc1bee2, 1'b0, 3'd0);
    send_word(32'h2e409f96, 1'b0, 3'd0);
    send_word(32'he93d7e11, 1'b0, 3'd0);
    send_word(32'h7393172a, 1'b1, 3'd4);
    tick();
    check_block("one", 128'h6bc1bee22e409f96e93d7e117393172a, 8'd128, 1'b1);
    pulse_done(1, 1'b1);

    // 40-byte message, block 2 assembled while block 1 is at the core
    send_word(32'hae2d8a57, 1'b0, 3'd0);
    send_word(32'h1e03ac9c, 1'b0, 3'd0);
    send_word(32'h9eb76fac, 1'b0, 3'd0);
    send_word(32'h45af8e51, 1'b0, 3'd0);
    send_word(32'hf69f2445, 1'b0, 3'd0);
    send_word(32'hdf4f9b17, 1'b0, 3'd0);
    send_word(32'had2b417b, 1'b0, 3'd0);
    send_word(32'he66c3710, 1'b0, 3'd0);
    check("both_full_ready", {127'd0, s_ready}, 128'd0);
    check("blk1_busy", {127'd0, busy}, 128'd1);
    check("blk1_data", cm_TextIn, BLK1);
    check("blk1_len", {120'd0, cm_Last_Block_Len}, 128'd128);
    check("blk1_last", {127'd0, cm_Last_Block}, 128'd0);
    tick();
    check("both_full_ready2", {127'd0, s_ready}, 128'd0);

    // Done held for 10 cycles; key_start is ignored while busy
    cm_Done = 1'b1;
    key_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      key_start = 1'b0;
      check("hold_no_ld", {126'd0, cm_ld_Block, cm_ld_Key}, 128'd0);
      check("hold_stable", cm_TextIn, BLK1);
    end
    cm_Done = 1'b0;
    tick();
    check("blk1_fall_busy", {127'd0, busy}, 128'd0);
    check("blk1_no_mac", {127'd0, mac_valid}, 128'd0);
    check("blk1_fall_ready", {127'd0, s_ready}, 128'd0);
    tick();
    check_block("blk2", BLK2, 8'd128, 1'b0);
    check("blk2_ready", {127'd0, s_ready}, 128'd1);
    send_word(32'h30c81c46, 1'b0, 3'd0);
    send_word(32'ha35ce411, 1'b1, 3'd4);
    pulse_done(1, 1'b0);
    check_block("blk3", BLK3, 8'd64, 1'b1);
    pulse_done(1, 1'b1);

    // Partial last word
    send_word(32'h11223344, 1'b0, 3'd0);
    send_word(32'h55667788, 1'b1, 3'd2);
    tick();
    check_block("part", {64'h1122334455660000, 64'd0}, 8'd48, 1'b1);
    pulse_done(1, 1'b1);

    // Last word carrying zero bytes after a full word
    send_word(32'haabbccdd, 1'b0, 3'd0);
    send_word(32'hffffffff, 1'b1, 3'd0);
    tick();
    check_block("zero_tail", {32'haabbccdd, 96'd0}, 8'd32, 1'b1);
    pulse_done(1, 1'b1);

    // Reset mid-block
    send_word(32'hdeadbeef, 1'b0, 3'd0);
    send_word(32'hcafef00d, 1'b0, 3'd0);
    #2;
    Rst_n = 1'b0;
    #1;
    check("midrst_outputs", {s_ready, cm_ld_Key, cm_ld_Block, cm_Last_Block, key_loaded, mac_valid, busy}, 128'd0);
    check("midrst_text", cm_TextIn, 128'd0);
    check("midrst_len", {120'd0, cm_Last_Block_Len}, 128'd0);
    tick();
    Rst_n = 1'b1;
    tick();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check("reld_key", {127'd0, cm_ld_Key}, 128'd1);
    pulse_done(1, 1'b0);
    send_word(32'h01020304, 1'b1, 3'd4);
    tick();
    check_block("post_rst", {32'h01020304, 96'd0}, 8'd32, 1'b1);
    pulse_done(1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
